// File: rtl/stimulus_sequencer.sv
// -----------------------------------------------------------------------------
// stimulus_sequencer
//
// Input stage for the combinational logic-function block. It turns three raw
// board switches and two pushbuttons into clean a/b/c drive signals.
//
//   MANUAL : the debounced switches drive {a,b,c} directly.
//   AUTO   : a 3-bit counter sweeps 000..111 and advances every STEP_CYCLES clocks.
//   STEP   : the counter advances once per debounced btn_step press.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   sw[2:0]    raw switches (sw[2]->a, sw[1]->b, sw[0]->c), asynchronous
//   btn_mode   raw pushbutton, cycles MANUAL->AUTO->STEP->MANUAL
//   btn_step   raw pushbutton, single step in STEP mode
//   a, b, c    registered drive to the function block
//   mode[1:0]  00 MANUAL, 01 AUTO, 10 STEP
//   changed    one-cycle pulse after {a,b,c} takes a new value
//   wrap       one-cycle pulse, aligned with changed, for a counter 111->000 roll
// -----------------------------------------------------------------------------
module stimulus_sequencer #(
    parameter int DEB_CYCLES  = 16,
    parameter int STEP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sw,
    input  logic       btn_mode,
    input  logic       btn_step,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [1:0] mode,
    output logic       changed,
    output logic       wrap
);

    localparam int NIN    = 5;
    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int STEP_W = $clog2(STEP_CYCLES);

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_STEP   = 2'b10
    } mode_t;

    // Bit order: [2:0] switches, [3] btn_mode, [4] btn_step
    logic [NIN-1:0] raw_in;
    logic [NIN-1:0] sync1_reg;
    logic [NIN-1:0] sync2_reg;
    logic [NIN-1:0] stable_w;

    assign raw_in = {btn_step, btn_mode, sw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
        end
    end

    // One debouncer per input: a new level is accepted only after it has been
    // seen for DEB_CYCLES consecutive synchronised cycles.
    genvar gi;
    generate
        for (gi = 0; gi < NIN; gi++) begin : g_deb
            logic             stable_reg;
            logic [DEB_W-1:0] deb_cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stable_reg  <= 1'b0;
                    deb_cnt_reg <= '0;
                end else if (sync2_reg[gi] == stable_reg) begin
                    deb_cnt_reg <= '0;
                end else if (deb_cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
                    stable_reg  <= sync2_reg[gi];
                    deb_cnt_reg <= '0;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + 1'b1;
                end
            end

            assign stable_w[gi] = stable_reg;
        end
    endgenerate

    mode_t             mode_reg;
    logic [NIN-1:0]    stable_q_reg;   // one-cycle delayed debounced levels
    logic              mode_evt_reg;
    logic              step_evt_reg;
    logic [2:0]        cnt_reg;
    logic [STEP_W-1:0] timer_reg;
    logic [2:0]        abc_reg;
    logic [2:0]        abc_prev_reg;
    logic              changed_reg;
    logic              wrap_inc_reg;   // set on the edge cnt rolls 111->000
    logic              wrap_dly_reg;   // lines wrap up with the changed pulse
    logic              wrap_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg     <= MODE_MANUAL;
            stable_q_reg <= '0;
            mode_evt_reg <= 1'b0;
            step_evt_reg <= 1'b0;
            cnt_reg      <= '0;
            timer_reg    <= '0;
            abc_reg      <= '0;
            abc_prev_reg <= '0;
            changed_reg  <= 1'b0;
            wrap_inc_reg <= 1'b0;
            wrap_dly_reg <= 1'b0;
            wrap_reg     <= 1'b0;
        end else begin
            stable_q_reg <= stable_w;
            mode_evt_reg <= stable_w[3] & ~stable_q_reg[3];
            step_evt_reg <= stable_w[4] & ~stable_q_reg[4];
            wrap_inc_reg <= 1'b0;

            // A mode event takes priority and drops any increment in that cycle.
            if (mode_evt_reg) begin
                timer_reg <= '0;
                case (mode_reg)
                    MODE_MANUAL: begin
                        mode_reg <= MODE_AUTO;
                        // Start the sweep from the switch value so {a,b,c} holds.
                        cnt_reg  <= stable_q_reg[2:0];
                    end
                    MODE_AUTO: mode_reg <= MODE_STEP;
                    default:   mode_reg <= MODE_MANUAL;
                endcase
            end else if (mode_reg == MODE_AUTO) begin
                if (timer_reg == STEP_W'(STEP_CYCLES - 1)) begin
                    timer_reg    <= '0;
                    cnt_reg      <= cnt_reg + 3'd1;
                    wrap_inc_reg <= (cnt_reg == 3'b111);
                end else begin
                    timer_reg <= timer_reg + 1'b1;
                end
            end else begin
                timer_reg <= '0;
                if (mode_reg == MODE_STEP && step_evt_reg) begin
                    cnt_reg      <= cnt_reg + 3'd1;
                    wrap_inc_reg <= (cnt_reg == 3'b111);
                end
            end

            abc_reg      <= (mode_reg == MODE_MANUAL) ? stable_q_reg[2:0] : cnt_reg;
            abc_prev_reg <= abc_reg;
            changed_reg  <= (abc_reg != abc_prev_reg);
            wrap_dly_reg <= wrap_inc_reg;
            wrap_reg     <= wrap_dly_reg;
        end
    end

    assign a       = abc_reg[2];
    assign b       = abc_reg[1];
    assign c       = abc_reg[0];
    assign mode    = mode_reg;
    assign changed = changed_reg;
    assign wrap    = wrap_reg;

endmodule

// File: tb/tb_stimulus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stimulus_sequencer
//
// Drives directed scenarios and a randomized phase into stimulus_sequencer.
// A reference model keeps per-cycle histories of the raw inputs and derives
// the debounced levels, mode, counter and outputs from the behavioural rules
// (level accepted after DEB consecutive equal samples, elapsed-time AUTO
// advance, fixed pipeline latencies). Every cycle the DUT outputs are compared
// with the model; directed scenarios add explicit checks against constants.
// -----------------------------------------------------------------------------
module tb_stimulus_sequencer;

    localparam int DEB  = 16;
    localparam int STEP = 8;
    localparam int N    = 8192;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sw = 3'b000;
    logic       btn_mode = 1'b0;
    logic       btn_step = 1'b0;
    logic       a, b, c, changed, wrap;
    logic [1:0] mode;

    always #5 clk = ~clk;

    stimulus_sequencer #(
        .DEB_CYCLES  (DEB),
        .STEP_CYCLES (STEP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn_mode (btn_mode),
        .btn_step (btn_step),
        .a        (a),
        .b        (b),
        .c        (c),
        .mode     (mode),
        .changed  (changed),
        .wrap     (wrap)
    );

    int total = 0;
    int bad   = 0;
    int k     = 0;        // model cycle index: edges since reset release
    int last_adv = 0;     // edge of last mode change or AUTO advance
    int chg_pulses = 0;

    // Raw bit order: [2:0] sw, [3] btn_mode, [4] btn_step
    logic [4:0] raw_h  [N];
    logic [4:0] deb_h  [N];
    logic [1:0] mode_h [N];
    logic [2:0] cnt_h  [N];
    logic [2:0] abc_h  [N];
    logic       wi_h   [N];

    logic [2:0] obs_prev;
    int         chg_k_q[$];
    logic [2:0] chg_v_q[$];
    int         wrap_k_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s k=%0d got=%0h expected=%0h", tag, k, got, exp);
        end
    endtask

    function automatic logic [4:0] graw(int i); return (i < 0) ? 5'b0 : raw_h[i]; endfunction
    function automatic logic [4:0] gdeb(int i); return (i < 0) ? 5'b0 : deb_h[i]; endfunction
    function automatic logic [1:0] gmode(int i); return (i < 0) ? 2'b0 : mode_h[i]; endfunction
    function automatic logic [2:0] gcnt(int i); return (i < 0) ? 3'b0 : cnt_h[i]; endfunction
    function automatic logic [2:0] gabc(int i); return (i < 0) ? 3'b0 : abc_h[i]; endfunction
    function automatic logic gwi(int i); return (i < 0) ? 1'b0 : wi_h[i]; endfunction

    function automatic int qk(int i); return (i < chg_k_q.size()) ? chg_k_q[i] : -1; endfunction
    function automatic int qv(int i); return (i < chg_v_q.size()) ? int'(chg_v_q[i]) : -1; endfunction
    function automatic int qw(int i); return (i < wrap_k_q.size()) ? wrap_k_q[i] : -1; endfunction

    // Model state after edge k.
    task automatic model_update();
        logic [4:0] pd, nd, r1, rj, d2, d3;
        logic [1:0] pm, nm;
        logic [2:0] pc, nc;
        logic       evm, evs, w, ok;
        pd = gdeb(k - 1);
        nd = pd;
        r1 = graw(k - 2);   // synchronised sample seen at this edge
        for (int i = 0; i < 5; i++) begin
            ok = 1'b1;
            for (int j = 1; j <= DEB; j++) begin
                rj = graw(k - 1 - j);
                if (rj[i] !== r1[i]) ok = 1'b0;
            end
            if (ok && (r1[i] != pd[i])) nd[i] = r1[i];
        end
        deb_h[k] = nd;

        d2  = gdeb(k - 2);
        d3  = gdeb(k - 3);
        evm = d2[3] & ~d3[3];
        evs = d2[4] & ~d3[4];
        pm  = gmode(k - 1);
        pc  = gcnt(k - 1);
        nm  = pm;
        nc  = pc;
        w   = 1'b0;
        if (evm) begin
            nm = (pm == 2'd0) ? 2'd1 : (pm == 2'd1) ? 2'd2 : 2'd0;
            if (pm == 2'd0) nc = d2[2:0];
            last_adv = k;
        end else if (pm == 2'd1 && (k - last_adv) == STEP) begin
            nc = pc + 3'd1;
            w  = (pc == 3'd7);
            last_adv = k;
        end else if (pm == 2'd2 && evs) begin
            nc = pc + 3'd1;
            w  = (pc == 3'd7);
        end
        mode_h[k] = nm;
        cnt_h[k]  = nc;
        wi_h[k]   = w;
        abc_h[k]  = (pm == 2'd0) ? d2[2:0] : pc;
    endtask

    // One clock: drive at the falling edge, check at the next falling edge.
    task automatic step(input logic [4:0] r);
        logic exp_chg, exp_wrap;
        if (k >= N - 1) begin
            $display("FAIL model_overflow k=%0d got=%0d expected<%0d", k, k, N - 1);
            $fatal(1);
        end
        raw_h[k] = r;
        sw       = r[2:0];
        btn_mode = r[3];
        btn_step = r[4];
        @(posedge clk);
        model_update();
        @(negedge clk);
        exp_chg  = (gabc(k - 1) != gabc(k - 2));
        exp_wrap = gwi(k - 2);
        check_eq("cyc", 32'({a, b, c, mode, changed, wrap}),
                 32'({abc_h[k], mode_h[k], exp_chg, exp_wrap}));
        if ({a, b, c} !== obs_prev) begin
            chg_k_q.push_back(k);
            chg_v_q.push_back({a, b, c});
        end
        obs_prev = {a, b, c};
        if (wrap) wrap_k_q.push_back(k);
        if (changed) chg_pulses++;
        k++;
    endtask

    task automatic hold(input logic [4:0] r, input int n);
        for (int i = 0; i < n; i++) step(r);
    endtask

    task automatic clear_obs();
        chg_k_q.delete();
        chg_v_q.delete();
        wrap_k_q.delete();
        chg_pulses = 0;
    endtask

    task automatic restart_model();
        k        = 0;
        last_adv = 0;
        obs_prev = 3'b000;
        clear_obs();
    endtask

    initial begin
        logic [4:0] r;
        int         len;

        // Reset held with all switches on
        obs_prev = 3'b000;
        sw = 3'b111;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_out", 32'({a, b, c, mode, changed, wrap}), 32'd0);
        rst_n = 1'b1;
        restart_model();
        hold(5'b00111, DEB + 10);
        check_eq("man_lat", 32'(qk(0)), 32'(DEB + 3));
        check_eq("man_val", 32'(qv(0)), 32'd7);
        check_eq("man_pulses", 32'(chg_pulses), 32'd1);

        // Glitch rejection on sw[0]
        hold(5'b00110, DEB + 10);
        clear_obs();
        for (int i = 0; i < 10; i++) step(5'b00110 | 5'(i & 1));
        hold(5'b00110, DEB + 10);
        check_eq("glitch_chg", 32'(chg_pulses), 32'd0);
        check_eq("glitch_c", 32'(c), 32'd0);
        hold(5'b00111, DEB + 10);
        check_eq("deb_hold_c", 32'(c), 32'd1);
        hold(5'b00110, DEB + 10);

        // AUTO sweep from 110, then STEP entry at cnt=011
        clear_obs();
        hold(5'b01110, 20);
        hold(5'b00110, 23);
        check_eq("auto_mode", 32'(mode), 32'd1);
        hold(5'b01110, 20);
        hold(5'b00110, 30);
        check_eq("auto_v0", 32'(qv(0)), 32'd7);
        check_eq("auto_v1", 32'(qv(1)), 32'd0);
        check_eq("auto_v2", 32'(qv(2)), 32'd1);
        check_eq("auto_period", 32'(qk(1) - qk(0)), 32'(STEP));
        check_eq("auto_period2", 32'(qk(2) - qk(1)), 32'(STEP));
        check_eq("auto_wrap_k", 32'(qw(0)), 32'(qk(1) + 1));
        check_eq("auto_nchg", 32'(chg_v_q.size()), 32'd5);
        check_eq("step_mode", 32'(mode), 32'd2);
        check_eq("step_start", 32'({a, b, c}), 32'd3);

        // STEP mode: three presses, then idle with no timed advance
        clear_obs();
        repeat (3) begin
            hold(5'b10110, 20);
            hold(5'b00110, 25);
        end
        hold(5'b00110, 40);
        check_eq("step_nchg", 32'(chg_v_q.size()), 32'd3);
        check_eq("step_v0", 32'(qv(0)), 32'd4);
        check_eq("step_v1", 32'(qv(1)), 32'd5);
        check_eq("step_v2", 32'(qv(2)), 32'd6);
        check_eq("step_pulses", 32'(chg_pulses), 32'd3);

        // Collision: mode and step events in the same cycle while in STEP
        clear_obs();
        hold(5'b11110, 20);
        hold(5'b00110, 30);
        check_eq("coll_mode", 32'(mode), 32'd0);
        check_eq("coll_abc", 32'({a, b, c}), 32'd6);
        check_eq("coll_nchg", 32'(chg_pulses), 32'd0);

        // btn_step in MANUAL is ignored
        clear_obs();
        hold(5'b10110, 20);
        hold(5'b00110, 30);
        check_eq("man_step", 32'(chg_pulses), 32'd0);

        // Randomized phase
        for (int seg = 0; seg < 120; seg++) begin
            r[2:0] = 3'($urandom);
            r[3]   = ($urandom % 4) == 0;
            r[4]   = ($urandom % 3) == 0;
            len    = int'($urandom_range(1, 40));
            hold(r, len);
        end

        // Reach AUTO, wait for 101, then reset asynchronously mid-cycle
        hold(5'b00000, 25);
        for (int t = 0; t < 4 && mode !== 2'b01; t++) begin
            hold(5'b01000, 20);
            hold(5'b00000, 25);
        end
        check_eq("pre_rst_auto", 32'(mode), 32'd1);
        for (int t = 0; t < 100 && {a, b, c} !== 3'b101; t++) step(5'b00000);
        check_eq("wait_101", 32'({a, b, c}), 32'd5);
        #2 rst_n = 1'b0;
        #1 check_eq("async_rst", 32'({a, b, c, mode, changed, wrap}), 32'd0);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check_eq("rst_nowrap", 32'({wrap, changed}), 32'd0);
        end
        rst_n = 1'b1;
        restart_model();
        hold(5'b00101, DEB + 10);
        check_eq("post_rst_abc", 32'({a, b, c, mode}), 32'({3'b101, 2'b00}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stimulus_sequencer.md
# stimulus_sequencer

Input stage for the combinational logic-function block. It turns three raw board switches and two pushbuttons into clean, glitch-free `a`, `b`, `c` drive signals. Inputs are synchronised and debounced. In MANUAL mode the switches pass straight through. In AUTO and STEP modes a 3-bit counter sweeps the full truth table 000..111, either timed or one step per button press. The outputs connect directly to the function block's `a`, `b`, `c` inputs, and the strobes let a downstream capture/display stage sample each new input vector.

## Interface
- `DEB_CYCLES`, default 16: consecutive stable cycles required to accept a new input level; must be ≥1.
- `STEP_CYCLES`, default 8: clock cycles between counter advances in AUTO mode; must be ≥2.
- `clk` in 1: single system clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sw` in 3: raw switches, asynchronous. `sw[2]`→`a`, `sw[1]`→`b`, `sw[0]`→`c`.
- `btn_mode` in 1: raw pushbutton, asynchronous; advances the mode.
- `btn_step` in 1: raw pushbutton, asynchronous; single-step in STEP mode.
- `a`, `b`, `c` out 1 each: registered drive to the function block.
- `mode` out 2: 00 MANUAL, 01 AUTO, 10 STEP; 11 is never produced.
- `changed` out 1: one-cycle pulse when {a,b,c} takes a new value.
- `wrap` out 1: one-cycle pulse when the counter rolls 111→000.

## Operation
- **Synchronisers:** every raw input (`sw[2:0]`, `btn_mode`, `btn_step`) passes through a 2-FF synchroniser.
- **Debouncer, one per input:**
  - Each has a stable bit and a counter sized for DEB_CYCLES.
  - When the synced value ≠ stable, the counter increments.
  - When the counter would reach DEB_CYCLES, stable takes the synced value and the counter clears.
  - Any cycle with synced == stable clears the counter.
- **Button edges:** a button event is a 0→1 transition of its debounced stable bit, one cycle wide.
- **Mode FSM:** each `btn_mode` event advances MANUAL→AUTO→STEP→MANUAL.
- **Counter `cnt[2:0]`:**
  - On leaving MANUAL for AUTO, `cnt` loads the debounced `sw` value, so the outputs do not jump.
  - AUTO→STEP keeps `cnt`.
  - Wraps modulo 8.
- **Step timer (AUTO only):**
  - Counts 0..STEP_CYCLES-1.
  - At the terminal count, `cnt` increments and the timer returns to 0.
  - The timer clears on every mode change and is held at 0 outside AUTO.
- **STEP mode:** each `btn_step` event increments `cnt`. `btn_step` events in other modes are ignored.
- **Output select:** MANUAL drives {a,b,c} from the debounced `sw`; AUTO and STEP drive {a,b,c} from `cnt`. {a,b,c} is registered.
- **`changed`:** high for exactly one cycle after any cycle in which the registered {a,b,c} differs from its previous value.
- **`wrap`:** high in the same cycle as the `changed` caused by a `cnt` 111→000 increment. A mode change that happens to produce 000 does not assert `wrap`.
- **Simultaneous events:**
  - A mode event in the same cycle as a step event or a timer terminal count: the mode change wins and the increment is dropped.
  - A `btn_step` event in the cycle it enters STEP mode is dropped.

## Timing
- **Reset values** (asynchronous assertion, applied immediately):
  - `a`=`b`=`c`=0, `mode`=00, `changed`=0, `wrap`=0.
  - `cnt`=0, timer=0, all synchronisers and debouncer stable bits and counters = 0.
- **Reset release:** synchronous to `clk`. A reset asserted mid-sweep returns to MANUAL with all outputs 0.
- **MANUAL latency:** a switch change first sampled at edge 0 and held appears on `a`/`b`/`c` at edge DEB_CYCLES+3. `changed` pulses at edge DEB_CYCLES+4.
- **Button latency:** a button press sampled at edge 0 produces its event at edge DEB_CYCLES+2. The resulting `mode` or `cnt` change is visible at edge DEB_CYCLES+3, and {a,b,c} at edge DEB_CYCLES+4.
- **AUTO period:** after entering AUTO, {a,b,c} advances every STEP_CYCLES cycles. The first advance comes STEP_CYCLES cycles after the mode register update.
- **Glitch rejection:** a glitch shorter than DEB_CYCLES synced cycles never changes the outputs.

## Test plan
- **Reset:**
  - Stimulus: hold `rst_n`=0 with `sw`=111, then release.
  - Required: all outputs 0, `mode`=00.
  - Then `a`/`b`/`c`=1 exactly DEB_CYCLES+3 cycles after the first post-reset sampling edge, with one `changed` pulse.
- **Debounce:**
  - Stimulus (DEB_CYCLES=16): toggle `sw[0]` for 10 cycles, then return it.
  - Required: `c` stays 0 and there is no `changed`.
  - Hold `sw[0]`=1 for 16+ cycles → `c`=1.
- **AUTO sweep:**
  - Stimulus: `sw`=110 in MANUAL, then one `btn_mode` press (STEP_CYCLES=8).
  - Required: `mode`=01 and {a,b,c} holds 110.
  - Then 111, 000 (with `wrap`=1), 001, each 8 cycles apart.
- **STEP mode:**
  - Stimulus: from AUTO at `cnt`=011, press `btn_mode`, then 3 `btn_step` presses.
  - Required: `mode`=10, {a,b,c} 011→100→101→110, one `changed` per press, no timed advance.
- **Collision:**
  - Stimulus: debounced `btn_mode` and `btn_step` events in the same cycle while in STEP.
  - Required: `mode`→00 and no `cnt` increment.
  - Then a `btn_step` press in MANUAL leaves {a,b,c} unchanged.
- **Mid-operation reset:**
  - Stimulus: assert `rst_n`=0 asynchronously mid-AUTO at `cnt`=101.
  - Required: outputs 0 and `mode`=00 without waiting for a clock edge; no `wrap` pulse.
